// File: rtl/adsr_env.sv
// ADSR envelope controller for the synth voice amplifier.
// Steps a 16-bit amplitude through attack / decay / sustain / release,
// driven by the voice gate. The amplitude updates once per envelope tick,
// which comes from a prescaler dividing the system clock.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   gate         note gate, high while the key is held
//   attack_step  amplitude increment per tick in ATTACK (0 = instant)
//   decay_step   amplitude decrement per tick in DECAY (0 = instant)
//   sustain_lvl  sustain amplitude
//   release_step amplitude decrement per tick in RELEASE (0 = instant)
//   amp_out      envelope amplitude
//   state_out    IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   active       high whenever the envelope is not IDLE
module adsr_env #(
    parameter int unsigned CLKSPEED = 50_000_000,
    parameter int unsigned TICK_HZ  = 10_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gate,
    input  logic [15:0] attack_step,
    input  logic [15:0] decay_step,
    input  logic [15:0] sustain_lvl,
    input  logic [15:0] release_step,
    output logic [15:0] amp_out,
    output logic [2:0]  state_out,
    output logic        active
);

    localparam int unsigned DIV     = CLKSPEED / TICK_HZ;
    localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AMP_W   = 16;
    localparam int unsigned EXT_W   = AMP_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [AMP_W-1:0] AMP_MAX = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [AMP_W-1:0]   amp_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               gate_q;
    logic               tick;
    logic               rise;
    logic               fall;
    logic [EXT_W-1:0]   sum_a;
    logic [EXT_W-1:0]   diff_d;
    logic [EXT_W-1:0]   diff_r;

    // Envelope tick prescaler: wraps at DIV-1, tick marks the wrap cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

    // Gate edge detection; gate_q clears in reset so a held gate retriggers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= gate;
        end
    end

    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;

    // 17-bit ramp arithmetic; bit 16 is carry (attack) or borrow (decay/release).
    assign sum_a  = {1'b0, amp_out} + {1'b0, attack_step};
    assign diff_d = {1'b0, amp_out} - {1'b0, decay_step};
    assign diff_r = {1'b0, amp_out} - {1'b0, release_step};

    // State and amplitude registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            amp_out <= '0;
            active  <= 1'b0;
        end else begin
            state   <= state_nxt;
            amp_out <= amp_nxt;
            active  <= (state_nxt != IDLE);
        end
    end

    assign state_out = state;

    // Next state / amplitude. Gate edges only move the state and hold the
    // amplitude, so a tick landing on an edge cycle is consumed silently.
    always_comb begin
        state_nxt = state;
        amp_nxt   = amp_out;
        if (rise) begin
            state_nxt = ATTACK;
        end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state_nxt = RELEASE;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    amp_nxt = '0;
                end
                ATTACK: begin
                    if (sum_a >= EXT_W'(AMP_MAX) || attack_step == '0) begin
                        amp_nxt   = AMP_MAX;
                        state_nxt = DECAY;
                    end else begin
                        amp_nxt = sum_a[AMP_W-1:0];
                    end
                end
                DECAY: begin
                    if (diff_d[AMP_W] || diff_d[AMP_W-1:0] <= sustain_lvl || decay_step == '0) begin
                        amp_nxt   = sustain_lvl;
                        state_nxt = SUSTAIN;
                    end else begin
                        amp_nxt = diff_d[AMP_W-1:0];
                    end
                end
                SUSTAIN: begin
                    amp_nxt = sustain_lvl;
                end
                RELEASE: begin
                    if (diff_r[AMP_W] || diff_r[AMP_W-1:0] == '0 || release_step == '0) begin
                        amp_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        amp_nxt = diff_r[AMP_W-1:0];
                    end
                end
                default: begin
                    amp_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adsr_env.sv
// Directed bench for adsr_env with DIV = 10 (CLKSPEED=100, TICK_HZ=10).
// cyc counts clock edges since the last reset edge, so ticks land on
// edges where cyc is a multiple of 10.
module tb_adsr_env;

    logic        clk;
    logic        rst_n;
    logic        gate;
    logic [15:0] attack_step;
    logic [15:0] decay_step;
    logic [15:0] sustain_lvl;
    logic [15:0] release_step;
    logic [15:0] amp_out;
    logic [2:0]  state_out;
    logic        active;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    adsr_env #(
        .CLKSPEED (100),
        .TICK_HZ  (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gate         (gate),
        .attack_step  (attack_step),
        .decay_step   (decay_step),
        .sustain_lvl  (sustain_lvl),
        .release_step (release_step),
        .amp_out      (amp_out),
        .state_out    (state_out),
        .active       (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int          upto;
        logic        g;
        logic [15:0] atk;
        logic [15:0] dec;
        logic [15:0] sus;
        logic [15:0] rel;
        logic [15:0] amp;
        logic [2:0]  st;
        logic        act;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    function automatic vec_t mk(int upto, logic g, logic [15:0] atk, logic [15:0] amp,
                                logic [2:0] st, logic act);
        vec_t v;
        v.upto = upto;
        v.g    = g;
        v.atk  = atk;
        v.dec  = 16'h1000;
        v.sus  = 16'h8000;
        v.rel  = 16'h2000;
        v.amp  = amp;
        v.st   = st;
        v.act  = act;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] amp, input logic [2:0] st,
                       input logic act);
        total++;
        if (amp_out !== amp || state_out !== st || active !== act) begin
            bad++;
            $display("FAIL %s: got amp=%h state=%0d active=%b, want amp=%h state=%0d active=%b",
                     name, amp_out, state_out, active, amp, st, act);
        end
    endtask

    // Advance to the negedge after edge number target; bounded.
    task automatic run_to(input int target);
        int guard = 0;
        while (cyc < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != target) begin
            total++;
            bad++;
            $display("FAIL run_to: cyc=%0d want %0d", cyc, target);
        end
    endtask

    initial begin
        // Attack/decay/sustain/release, retrigger in release, rise on a tick.
        vecs[0]  = mk( 51, 1'b1, 16'h4000, 16'h0000, 3'd1, 1'b1);
        vecs[1]  = mk( 59, 1'b1, 16'h4000, 16'h0000, 3'd1, 1'b1);
        vecs[2]  = mk( 60, 1'b1, 16'h4000, 16'h4000, 3'd1, 1'b1);
        vecs[3]  = mk( 70, 1'b1, 16'h4000, 16'h8000, 3'd1, 1'b1);
        vecs[4]  = mk( 80, 1'b1, 16'h4000, 16'hC000, 3'd1, 1'b1);
        vecs[5]  = mk( 90, 1'b1, 16'h4000, 16'hFFFF, 3'd2, 1'b1);
        vecs[6]  = mk(100, 1'b1, 16'h4000, 16'hEFFF, 3'd2, 1'b1);
        vecs[7]  = mk(160, 1'b1, 16'h4000, 16'h8FFF, 3'd2, 1'b1);
        vecs[8]  = mk(169, 1'b1, 16'h4000, 16'h8FFF, 3'd2, 1'b1);
        vecs[9]  = mk(170, 1'b1, 16'h4000, 16'h8000, 3'd3, 1'b1);
        vecs[10] = mk(180, 1'b1, 16'h4000, 16'h8000, 3'd3, 1'b1);
        vecs[11] = mk(181, 1'b0, 16'h4000, 16'h8000, 3'd4, 1'b1);
        vecs[12] = mk(190, 1'b0, 16'h4000, 16'h6000, 3'd4, 1'b1);
        vecs[13] = mk(200, 1'b0, 16'h4000, 16'h4000, 3'd4, 1'b1);
        vecs[14] = mk(210, 1'b0, 16'h4000, 16'h2000, 3'd4, 1'b1);
        vecs[15] = mk(220, 1'b0, 16'h4000, 16'h0000, 3'd0, 1'b0);
        vecs[16] = mk(221, 1'b1, 16'h4000, 16'h0000, 3'd1, 1'b1);
        vecs[17] = mk(260, 1'b1, 16'h4000, 16'hFFFF, 3'd2, 1'b1);
        vecs[18] = mk(340, 1'b1, 16'h4000, 16'h8000, 3'd3, 1'b1);
        vecs[19] = mk(341, 1'b0, 16'h4000, 16'h8000, 3'd4, 1'b1);
        vecs[20] = mk(360, 1'b0, 16'h4000, 16'h4000, 3'd4, 1'b1);
        vecs[21] = mk(361, 1'b1, 16'h4000, 16'h4000, 3'd1, 1'b1);
        vecs[22] = mk(370, 1'b1, 16'h4000, 16'h8000, 3'd1, 1'b1);
        vecs[23] = mk(371, 1'b0, 16'h4000, 16'h8000, 3'd4, 1'b1);
        vecs[24] = mk(389, 1'b0, 16'h0000, 16'h6000, 3'd4, 1'b1);
        vecs[25] = mk(390, 1'b1, 16'h0000, 16'h6000, 3'd1, 1'b1);
        vecs[26] = mk(399, 1'b1, 16'h0000, 16'h6000, 3'd1, 1'b1);
        vecs[27] = mk(400, 1'b1, 16'h0000, 16'hFFFF, 3'd2, 1'b1);
        vecs[28] = mk(410, 1'b1, 16'h0000, 16'hEFFF, 3'd2, 1'b1);

        rst_n        = 1'b0;
        gate         = 1'b0;
        attack_step  = 16'h4000;
        decay_step   = 16'h1000;
        sustain_lvl  = 16'h8000;
        release_step = 16'h2000;

        // Reset, then 50 idle clocks with the prescaler tick every 10th edge.
        repeat (3) @(negedge clk);
        chk("reset", 16'h0000, 3'd0, 1'b0);
        rst_n = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            total++;
            if (dut.tick !== ((k % 10) == 9)) begin
                bad++;
                $display("FAIL tick@%0d: got %b want %b", k, dut.tick, ((k % 10) == 9));
            end
        end
        chk("idle50", 16'h0000, 3'd0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            gate         = vecs[i].g;
            attack_step  = vecs[i].atk;
            decay_step   = vecs[i].dec;
            sustain_lvl  = vecs[i].sus;
            release_step = vecs[i].rel;
            run_to(vecs[i].upto);
            chk($sformatf("vec%0d@%0d", i, vecs[i].upto), vecs[i].amp, vecs[i].st, vecs[i].act);
        end

        // One-clock reset mid-decay with gate held high.
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_decay", 16'h0000, 3'd0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rise_after_rst", 16'h0000, 3'd1, 1'b1);
        run_to(10);
        chk("instant_attack", 16'hFFFF, 3'd2, 1'b1);

        // sustain at full scale exits decay on the first tick at 0xFFFF.
        sustain_lvl = 16'hFFFF;
        run_to(20);
        chk("sustain_max", 16'hFFFF, 3'd3, 1'b1);

        // sustain at zero holds amp 0 while still active.
        sustain_lvl = 16'h0000;
        run_to(30);
        chk("sustain_zero", 16'h0000, 3'd3, 1'b1);

        gate = 1'b0;
        run_to(31);
        chk("release_from_zero", 16'h0000, 3'd4, 1'b1);
        run_to(40);
        chk("release_borrow", 16'h0000, 3'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
